digit_serial_adder: RTL

Parametrised multi-cycle adder/subtractor. It replaces the fixed 4-bit registered ripple-carry adder with a configurable-width datapath processed DIGIT bits per clock. Operands are captured on a load handshake and processed LSB-digit first through a DIGIT-bit ripple slice with a registered carry. The full result plus flags is presented with a one-cycle done pulse. It sits between operand registers and the result/display logic of the arithmetic projects.

---
 rtl/digit_serial_adder_if.sv | 25 ++
 rtl/digit_serial_adder.sv | 117 +++++++++++
 2 files changed

// File: rtl/digit_serial_adder_if.sv
// Operand/result bundle for the digit-serial adder: load request, operands,
// mode, and the registered result with its status flags.
interface digit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   q;
  logic             ovf;

  modport master (
    output load, a, b, cin, sub,
    input  busy, done, q, ovf
  );

  modport slave (
    input  load, a, b, cin, sub,
    output busy, done, q, ovf
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed DIGIT bits per
// clock, LSB digit first, with the full result and flags presented on done.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input logic                clk,
  input logic                rst_n,
  digit_serial_adder_if.slave bus
);
  localparam int unsigned N       = WIDTH / DIGIT;
  localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SLICE_W = DIGIT + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sh, a_next;
  logic [WIDTH-1:0]   b_sh, b_next;
  logic [WIDTH-1:0]   acc, acc_next;
  logic               carry, carry_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               busy_r, busy_next;
  logic               done_r, done_next;
  logic [WIDTH:0]     q_r, q_next;
  logic               ovf_r, ovf_next;

  // One DIGIT-bit ripple slice on the low digit of the shifted operands
  logic [DIGIT-1:0]   a_dig, b_dig, sum_dig;
  logic [SLICE_W-1:0] slice;
  logic               c_out, c_msb;
  logic [WIDTH-1:0]   acc_shift;

  always_comb begin
    a_dig     = a_sh[DIGIT-1:0];
    b_dig     = b_sh[DIGIT-1:0];
    slice     = {1'b0, a_dig} + {1'b0, b_dig} + SLICE_W'(carry);
    sum_dig   = slice[DIGIT-1:0];
    c_out     = slice[DIGIT];
    // carry into the slice MSB recovered from that bit's sum and operands
    c_msb     = sum_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    acc_shift = (acc >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
  end

  // Next-state and register-input logic
  always_comb begin
    state_next = state;
    a_next     = a_sh;
    b_next     = b_sh;
    acc_next   = acc;
    carry_next = carry;
    cnt_next   = cnt;
    done_next  = 1'b0;
    q_next     = q_r;
    ovf_next   = ovf_r;

    case (state)
      IDLE: begin
        if (bus.load) begin
          a_next     = bus.a;
          b_next     = bus.sub ? ~bus.b : bus.b;
          carry_next = bus.sub ? ~bus.cin : bus.cin;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_next     = a_sh >> DIGIT;
        b_next     = b_sh >> DIGIT;
        acc_next   = acc_shift;
        carry_next = c_out;
        cnt_next   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(N - 1)) begin
          q_next     = {c_out, acc_shift};
          ovf_next   = c_msb ^ c_out;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      q_r    <= '0;
      ovf_r  <= 1'b0;
    end else begin
      state  <= state_next;
      a_sh   <= a_next;
      b_sh   <= b_next;
      acc    <= acc_next;
      carry  <= carry_next;
      cnt    <= cnt_next;
      busy_r <= busy_next;
      done_r <= done_next;
      q_r    <= q_next;
      ovf_r  <= ovf_next;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.q    = q_r;
  assign bus.ovf  = ovf_r;
endmodule
